proximity_filter: RTL and testbench
===================================

PROXIMITY_FILTER -- requirements
Module: proximity_filter

Interface
REQ-001 SHALL have parameter PERIOD, default 3700000, meaning clock cycles between measurement requests.
REQ-002 SHALL have parameter TIMEOUT, default 3000000, meaning cycles to wait for ultra_done after a request; TIMEOUT < PERIOD.
REQ-003 SHALL have parameter NEAR_TH, default 1000, meaning a distance strictly below this counts as a near sample.
REQ-004 SHALL have parameter FAR_TH, default 1200, meaning a distance at or above this counts as a far sample; FAR_TH >= NEAR_TH.
REQ-005 SHALL have parameter CONFIRM, default 2, range 1..15, meaning consecutive agreeing samples needed to change near.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port en, input, 1 bit: enables periodic ranging.
REQ-009 SHALL have port ultra_init, output, 1 bit: one-cycle measurement request to the ranger.
REQ-010 SHALL have port ultra_done, input, 1 bit: ranger completion pulse.
REQ-011 SHALL have port ultra_dist, input, 16 bits: ranger distance, valid when ultra_done=1.
REQ-012 SHALL have port near, output, 1 bit: filtered obstacle-close flag for the state machine.
REQ-013 SHALL have port dist_q, output, 16 bits: last accepted distance.
REQ-014 SHALL have port sample_valid, output, 1 bit: one-cycle pulse when dist_q and near update.
REQ-015 SHALL have port timeout_err, output, 1 bit: one-cycle pulse when a measurement times out.

Function
REQ-016 SHALL implement FSM states IDLE, TRIG, WAIT, EVAL.
REQ-017 SHALL run the period counter 0..PERIOD-1 and wrap to 0 while en=1, and hold it at 0 while en=0.
REQ-018 SHALL go IDLE->TRIG when the period counter equals PERIOD-1, and SHALL assert ultra_init for exactly the one TRIG cycle.
REQ-019 SHALL always go TRIG->WAIT on the next edge, and SHALL ignore ultra_done while in TRIG or IDLE.
REQ-020 SHALL, in WAIT, latch ultra_dist into the sample register and go to EVAL on ultra_done=1.
REQ-021 SHALL, in WAIT, after TIMEOUT cycles without done, load 16'hFFFF as the sample, pulse timeout_err, and go to EVAL.
REQ-022 SHALL give ultra_done priority when done and timeout occur in the same cycle, with no timeout_err.
REQ-023 SHALL, in EVAL, update dist_q, the confirm counters, and near, pulse sample_valid, and return to IDLE. This occurs one edge after WAIT exits, so outputs change on the 2nd edge after done is sampled.
REQ-024 SHALL, on a sample < NEAR_TH, increment near_cnt saturating at CONFIRM and clear far_cnt; SHALL, on a sample >= FAR_TH, increment far_cnt saturating and clear near_cnt; SHALL, on a sample in the band, clear both.
REQ-025 SHALL set near when near_cnt reaches CONFIRM, clear near when far_cnt reaches CONFIRM, and otherwise hold near (hysteresis).
REQ-026 SHALL use unsigned 16-bit comparisons, with 4-bit counters sized for CONFIRM.
REQ-027 SHALL, on en falling in any state, go to IDLE on the next edge, clear the counters and near, hold dist_q, and emit no pulses.
REQ-028 SHALL let the period counter keep running during WAIT/EVAL, and SHALL skip, not queue, a request that falls due outside IDLE.

Reset
REQ-029 SHALL, while rst=1, force: state IDLE, all counters 0, near=0, dist_q=16'hFFFF, ultra_init=0, sample_valid=0, timeout_err=0.
REQ-030 SHALL abandon any in-flight measurement on rst mid-WAIT, and SHALL start the first request PERIOD cycles after rst falls with en=1.

Structure
REQ-031 SHALL take the state encoding, the FAR sentinel 16'hFFFF, and the default thresholds/periods from shared package robot_pkg.
REQ-032 SHALL put the near/far counter-and-hysteresis logic in one sub-module, hyst_confirm, instantiated once.

Verification (bench parameters: PERIOD=100, TIMEOUT=60, CONFIRM=2, NEAR_TH=1000, FAR_TH=1200)
REQ-033 SHALL check: rst released, en=1 -> first ultra_init pulse exactly 100 cycles later, one cycle wide, repeating every 100.
REQ-034 SHALL check: done with dist=500 on two consecutive requests -> near=0 after the first, near=1 after the second; sample_valid and dist_q=500 two edges after each done.
REQ-035 SHALL check: with near=1, dist 1100 then 1300 then 1300 -> near stays 1 through 1100 and 1300, then clears after the second 1300.
REQ-036 SHALL check: no done for 60 cycles -> timeout_err pulse, dist_q=16'hFFFF; done and timeout in the same cycle with dist=700 -> dist_q=700, no timeout_err.
REQ-037 SHALL check: en dropped in WAIT, a stray done, then en restored -> no sample_valid, near=0, next ultra_init 100 cycles after en rises.
REQ-038 SHALL check: rst asserted mid-WAIT -> all outputs immediately at reset values, and a late done after release is ignored.

Source files
------------

// File: rtl/robot_pkg.sv
// robot_pkg: shared FSM encoding, far sentinel and default ranging parameters
package robot_pkg;
  typedef enum logic [1:0] {IDLE, TRIG, WAIT, EVAL} prox_state_e;
  localparam logic [15:0] FAR_SENTINEL = 16'hFFFF;
  localparam int DEF_PERIOD = 3700000;
  localparam int DEF_TIMEOUT = 3000000;
  localparam int DEF_NEAR_TH = 1000;
  localparam int DEF_FAR_TH = 1200;
  localparam int DEF_CONFIRM = 2;
endpackage

// File: rtl/hyst_confirm.sv
// hyst_confirm: near/far confirmation counters with hysteresis on the near flag
// Ports: clk, rst (async high); clr drops counters and near; upd applies sample;
// sample is the distance under evaluation; near is the confirmed obstacle flag.
module hyst_confirm import robot_pkg::*; #(
  parameter int NEAR_TH = DEF_NEAR_TH,
  parameter int FAR_TH  = DEF_FAR_TH,
  parameter int CONFIRM = DEF_CONFIRM
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        upd,
  input  logic [15:0] sample,
  output logic        near
);
  localparam logic [3:0] CMAX = 4'(CONFIRM);
  localparam logic [15:0] NTH = 16'(NEAR_TH);
  localparam logic [15:0] FTH = 16'(FAR_TH);
  logic [3:0] near_cnt_q, near_cnt_d, far_cnt_q, far_cnt_d;
  logic near_q, near_d, is_near, is_far;
  always_comb begin
    is_near = sample < NTH;
    is_far = sample >= FTH;
    near_cnt_d = clr ? 4'd0 : !upd ? near_cnt_q : !is_near ? 4'd0 : near_cnt_q == CMAX ? CMAX : near_cnt_q + 4'd1;
    far_cnt_d = clr ? 4'd0 : !upd ? far_cnt_q : !is_far ? 4'd0 : far_cnt_q == CMAX ? CMAX : far_cnt_q + 4'd1;
    near_d = clr ? 1'b0 : !upd ? near_q : near_cnt_d == CMAX ? 1'b1 : far_cnt_d == CMAX ? 1'b0 : near_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      near_cnt_q <= '0;
      far_cnt_q <= '0;
      near_q <= 1'b0;
    end else begin
      near_cnt_q <= near_cnt_d;
      far_cnt_q <= far_cnt_d;
      near_q <= near_d;
    end
  end
  assign near = near_q;
endmodule

// File: rtl/proximity_filter.sv
// proximity_filter: periodic ultrasonic ranging with timeout and confirmed near flag
// Ports: clk, rst (async high), en enables ranging; ultra_init requests a
// measurement; ultra_done/ultra_dist return it; near, dist_q, sample_valid
// report the filtered result; timeout_err pulses when the ranger stays silent.
module proximity_filter import robot_pkg::*; #(
  parameter int PERIOD  = DEF_PERIOD,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int NEAR_TH = DEF_NEAR_TH,
  parameter int FAR_TH  = DEF_FAR_TH,
  parameter int CONFIRM = DEF_CONFIRM
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        ultra_init,
  input  logic        ultra_done,
  input  logic [15:0] ultra_dist,
  output logic        near,
  output logic [15:0] dist_q,
  output logic        sample_valid,
  output logic        timeout_err
);
  localparam int CW = $clog2(PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);
  prox_state_e state_q, state_d;
  logic [CW-1:0] per_cnt_q, per_cnt_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] sample_q, sample_d, dist_d;
  logic sample_valid_q, sample_valid_d, timeout_err_q, timeout_err_d;
  logic per_due, in_wait, got, expired, eval;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Dropping en overrides every state so an in-flight measurement is abandoned.
  always_comb begin
    state_d = state_q;
    if (!en) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: state_d = per_due ? TRIG : IDLE;
        TRIG: state_d = WAIT;
        WAIT: state_d = (ultra_done || expired) ? EVAL : WAIT;
        EVAL: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    ultra_init = state_q == TRIG;
    sample_valid = sample_valid_q;
    timeout_err = timeout_err_q;
  end
  // Done wins over an expiring wait, so expired is only raised without done.
  always_comb begin
    per_due = per_cnt_q == CW'(PERIOD - 1);
    in_wait = en && state_q == WAIT;
    got = in_wait && ultra_done;
    expired = in_wait && !ultra_done && wait_cnt_q == TW'(TIMEOUT - 1);
    eval = en && state_q == EVAL;
    per_cnt_d = (!en || per_due) ? '0 : per_cnt_q + CW'(1);
    wait_cnt_d = in_wait ? wait_cnt_q + TW'(1) : '0;
    sample_d = got ? ultra_dist : expired ? FAR_SENTINEL : sample_q;
    dist_d = eval ? sample_q : dist_q;
    sample_valid_d = eval;
    timeout_err_d = expired;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_q <= '0;
      wait_cnt_q <= '0;
      sample_q <= FAR_SENTINEL;
      dist_q <= FAR_SENTINEL;
      sample_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      sample_q <= sample_d;
      dist_q <= dist_d;
      sample_valid_q <= sample_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  hyst_confirm #(.NEAR_TH(NEAR_TH), .FAR_TH(FAR_TH), .CONFIRM(CONFIRM)) u_hyst (
    .clk(clk),
    .rst(rst),
    .clr(!en),
    .upd(eval),
    .sample(sample_q),
    .near(near)
  );
endmodule

// File: tb/tb_proximity_filter.sv
// tb_proximity_filter: event-time reference model plus directed and random ranging traffic
module tb_proximity_filter;
  localparam int PERIOD = 100, TIMEOUT = 60, NEAR_TH = 1000, FAR_TH = 1200, CONFIRM = 2;
  logic clk = 0, rst = 1, en = 0, ultra_done = 0;
  logic [15:0] ultra_dist = 0;
  logic ultra_init, near, sample_valid, timeout_err;
  logic [15:0] dist_q;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  proximity_filter #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .NEAR_TH(NEAR_TH), .FAR_TH(FAR_TH), .CONFIRM(CONFIRM)) dut (
    .clk(clk), .rst(rst), .en(en), .ultra_init(ultra_init), .ultra_done(ultra_done),
    .ultra_dist(ultra_dist), .near(near), .dist_q(dist_q), .sample_valid(sample_valid),
    .timeout_err(timeout_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: tracks the edge index of each request (t0) and of the wait exit (x);
  // near follows "last CONFIRM samples all near / all far" over a sample history.
  int e = 0, run = 0, t0 = -1, x = -1;
  bit m_busy;
  logic [15:0] m_sample, m_dist = 16'hFFFF;
  logic m_init = 0, m_sv = 0, m_te = 0, m_near = 0;
  int hist[$];
  function automatic int cls(input logic [15:0] v);
    return v < NEAR_TH ? 0 : v >= FAR_TH ? 2 : 1;
  endfunction
  function automatic bit streak(input int c);
    if (hist.size() < CONFIRM) return 0;
    foreach (hist[i]) if (hist[i] != c) return 0;
    return 1;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      run = 0; t0 = -1; x = -1; hist.delete();
      m_dist = 16'hFFFF; m_near = 0; m_init = 0; m_sv = 0; m_te = 0;
    end else begin
      e++; m_init = 0; m_sv = 0; m_te = 0;
      if (!en) begin
        run = 0; t0 = -1; x = -1; hist.delete(); m_near = 0;
      end else begin
        m_busy = t0 >= 0;
        run++;
        if (x >= 0 && e == x + 1) begin
          m_dist = m_sample;
          hist.push_back(cls(m_sample));
          if (hist.size() > CONFIRM) void'(hist.pop_front());
          if (streak(0)) m_near = 1;
          else if (streak(2)) m_near = 0;
          m_sv = 1; t0 = -1; x = -1;
        end else if (t0 >= 0 && x < 0 && e > t0 + 1) begin
          if (ultra_done) begin m_sample = ultra_dist; x = e; end
          else if (e == t0 + 1 + TIMEOUT) begin m_sample = 16'hFFFF; x = e; m_te = 1; end
        end
        if (run % PERIOD == 0 && !m_busy) begin t0 = e; m_init = 1; end
      end
    end
  end
  always @(negedge clk) begin
    chk("ultra_init", ultra_init, m_init);
    chk("sample_valid", sample_valid, m_sv);
    chk("timeout_err", timeout_err, m_te);
    chk("near", near, m_near);
    chk("dist_q", dist_q, m_dist);
  end
  task automatic count_init(output int n);
    n = 0;
    repeat (3 * PERIOD) begin
      @(posedge clk); #1; n++;
      if (ultra_init) break;
    end
  endtask
  task automatic wait_init();
    int n;
    count_init(n);
    if (!ultra_init) chk("init_wait", 0, 1);
  endtask
  task automatic pulse_done(input logic [15:0] d);
    ultra_done = 1; ultra_dist = d;
    @(posedge clk); #1;
    ultra_done = 0;
  endtask
  task automatic measure(input int k, input logic [15:0] d);
    wait_init();
    repeat (k) begin @(posedge clk); #1; end
    pulse_done(d);
  endtask
  task automatic after_edge();
    @(posedge clk); #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, k;
    logic [15:0] d;
    rst = 1; en = 1;
    repeat (3) after_edge();
    chk("rst_dist", dist_q, 16'hFFFF);
    chk("rst_near", near, 0);
    chk("rst_init", ultra_init, 0);
    rst = 0;
    count_init(n); chk("first_init_delay", n, PERIOD);
    after_edge(); chk("init_width", ultra_init, 0);
    count_init(n); chk("init_repeat", n, PERIOD - 1);
    measure(5, 500); after_edge();
    chk("s1_valid", sample_valid, 1); chk("s1_dist", dist_q, 500); chk("s1_near", near, 0);
    measure(10, 500); after_edge();
    chk("s2_valid", sample_valid, 1); chk("s2_dist", dist_q, 500); chk("s2_near", near, 1);
    measure(3, 1100); after_edge(); chk("band_near", near, 1);
    measure(3, 1300); after_edge(); chk("far1_near", near, 1);
    measure(3, 1300); after_edge(); chk("far2_near", near, 0);
    wait_init();
    repeat (TIMEOUT + 1) after_edge();
    chk("to_pulse", timeout_err, 1);
    after_edge();
    chk("to_dist", dist_q, 16'hFFFF); chk("to_valid", sample_valid, 1); chk("to_pulse_end", timeout_err, 0);
    measure(TIMEOUT, 700);
    chk("tie_no_to", timeout_err, 0);
    after_edge(); chk("tie_dist", dist_q, 700); chk("tie_valid", sample_valid, 1);
    measure(5, 500); measure(5, 500); after_edge();
    chk("pre_drop_near", near, 1);
    wait_init();
    repeat (2) after_edge();
    en = 0;
    repeat (3) after_edge();
    pulse_done(300);
    repeat (5) after_edge();
    chk("drop_near", near, 0); chk("drop_dist", dist_q, 500); chk("drop_valid", sample_valid, 0);
    en = 1;
    count_init(n); chk("en_init_delay", n, PERIOD);
    measure(4, 400); measure(4, 400); after_edge();
    chk("pre_rst_near", near, 1);
    wait_init();
    repeat (3) after_edge();
    #2 rst = 1;
    #1;
    chk("mid_rst_init", ultra_init, 0); chk("mid_rst_near", near, 0);
    chk("mid_rst_dist", dist_q, 16'hFFFF); chk("mid_rst_valid", sample_valid, 0);
    chk("mid_rst_to", timeout_err, 0);
    repeat (2) after_edge();
    rst = 0;
    pulse_done(200);
    chk("late_done_dist", dist_q, 16'hFFFF);
    count_init(n); chk("rst_init_delay", n, PERIOD - 1);
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, TIMEOUT + 5);
      case ($urandom_range(0, 7))
        0: d = 500;
        1: d = 999;
        2: d = 1000;
        3: d = 1199;
        4: d = 1200;
        5: d = 16'hFFFF;
        default: d = 16'($urandom_range(0, 2000));
      endcase
      if ($urandom_range(0, 7) == 0) begin
        wait_init();
        repeat ($urandom_range(0, 70)) after_edge();
        en = 0;
        repeat ($urandom_range(1, 20)) after_edge();
        if ($urandom_range(0, 1) == 1) pulse_done(d);
        en = 1;
      end else measure(k, d);
    end
    repeat (5) after_edge();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
